mem_rd_arbiter: RTL and testbench

- Two-master to one-slave AXI-Lite read-channel arbiter that shares the single instruction/data memory port between the fetch unit (IFU) and the load/store unit (LSU).
- Sits between the IFU/LSU AXI-Lite read masters and the memory/crossbar read slave.
- Allows one outstanding transaction at a time.
- Arbitration is LSU-priority with a bounded-starvation guarantee for IFU.

---
 rtl/mem_rd_arbiter_if.sv | 21 ++
 rtl/mem_rd_arbiter.sv | 97 +++++++++
 tb/tb_mem_rd_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_rd_arbiter_if.sv
// AXI-Lite read channel (AR + R) bundle shared by the IFU, LSU and memory sides
// of the read arbiter.
interface mem_rd_arbiter_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-master AXI-Lite read arbiter: IFU and LSU share one memory read port with a
// single outstanding transaction, LSU priority and bounded IFU starvation.
module mem_rd_arbiter #(
    parameter int MAX_STREAK = 4
) (
    input  logic             clk,
    input  logic             reset,
    mem_rd_arbiter_if.slave  ifu,
    mem_rd_arbiter_if.slave  lsu,
    mem_rd_arbiter_if.master m,
    output logic             owner,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    localparam logic [2:0] STREAK_LIMIT = 3'(MAX_STREAK);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_owner;
    logic [2:0]  r_streak;
    logic [31:0] r_araddr;

    logic        w_idle;
    logic        w_force_ifu;
    logic        w_grant;
    logic        w_grant_lsu;
    logic        w_rready;

    // Arbitration is only live in S_IDLE and never while reset is held.
    assign w_idle      = (r_state == S_IDLE) && reset;
    assign w_force_ifu = (MAX_STREAK != 0) && (r_streak == STREAK_LIMIT);
    assign w_grant_lsu = lsu.arvalid && !(ifu.arvalid && w_force_ifu);
    assign w_grant     = w_idle && (ifu.arvalid || lsu.arvalid);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_next_state = r_state;
        ifu.arready  = 1'b0;
        lsu.arready  = 1'b0;
        ifu.rvalid   = 1'b0;
        lsu.rvalid   = 1'b0;
        w_rready     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next_state = S_ADDR;
                    ifu.arready  = !w_grant_lsu;
                    lsu.arready  = w_grant_lsu;
                end
            end
            S_ADDR: begin
                if (m.arready) w_next_state = S_DATA;
            end
            S_DATA: begin
                w_rready   = r_owner ? lsu.rready : ifu.rready;
                ifu.rvalid = !r_owner && m.rvalid;
                lsu.rvalid = r_owner && m.rvalid;
                if (m.rvalid && w_rready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_streak <= '0;
            r_araddr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state <= w_next_state;
            if (w_grant) begin
                r_owner  <= w_grant_lsu;
                r_araddr <= w_grant_lsu ? lsu.araddr : ifu.araddr;
                if (w_grant_lsu && ifu.arvalid)
                    r_streak <= (r_streak == 3'd7) ? r_streak : r_streak + 3'd1;
                else
                    r_streak <= '0;
            end
        end
    end

    assign m.araddr  = r_araddr;
    assign m.arvalid = (r_state == S_ADDR);
    assign m.rready  = w_rready;

    // Read data is broadcast; only the owner's rvalid qualifies it.
    assign ifu.rdata = m.rdata;
    assign ifu.rresp = m.rresp;
    assign lsu.rdata = m.rdata;
    assign lsu.rresp = m.rresp;

    assign owner = r_owner;
    assign busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Randomized self-checking bench for mem_rd_arbiter against a transaction-level
// arbitration model (grant rule + starvation counter).
module tb_mem_rd_arbiter;
    localparam int MAX_STREAK = 4;

    logic clk;
    logic reset;
    logic owner;
    logic busy;

    int n_pass   = 0;
    int n_total  = 0;
    int streak_m = 0;

    mem_rd_arbiter_if ifu_bus ();
    mem_rd_arbiter_if lsu_bus ();
    mem_rd_arbiter_if mem_bus ();

    mem_rd_arbiter #(.MAX_STREAK(MAX_STREAK)) dut (
        .clk   (clk),
        .reset (reset),
        .ifu   (ifu_bus.slave),
        .lsu   (lsu_bus.slave),
        .m     (mem_bus.master),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Grant rule: a lone requester wins; on contention LSU wins unless IFU has
    // already lost MAX_STREAK times in a row while waiting.
    function automatic bit model_pick_lsu(input bit ifu_req, input bit lsu_req);
        if (!lsu_req) return 1'b0;
        if (!ifu_req) return 1'b1;
        return !(MAX_STREAK != 0 && streak_m == MAX_STREAK);
    endfunction

    task automatic model_update(input bit ifu_req, input bit lsu_wins);
        if (lsu_wins && ifu_req) streak_m = (streak_m < 7) ? streak_m + 1 : 7;
        else streak_m = 0;
    endtask

    task automatic quiet_inputs();
        ifu_bus.araddr  = '0; ifu_bus.arvalid = 1'b0; ifu_bus.rready = 1'b0;
        lsu_bus.araddr  = '0; lsu_bus.arvalid = 1'b0; lsu_bus.rready = 1'b0;
        mem_bus.arready = 1'b0; mem_bus.rvalid = 1'b0;
        mem_bus.rdata   = '0;   mem_bus.rresp  = 2'b00;
    endtask

    // One full arbitration round, entered and left just after a falling edge with the DUT idle.
    task automatic do_txn(input bit ifu_req, input bit lsu_req,
                          input logic [31:0] ifu_addr, input logic [31:0] lsu_addr,
                          input int ar_wait, input int r_wait, input int rr_wait,
                          input logic [31:0] rdata, input logic [1:0] rresp);
        bit          exp_lsu;
        bit          rv;
        bit          rel;
        logic [31:0] exp_addr;

        ifu_bus.araddr  = ifu_addr;
        ifu_bus.arvalid = ifu_req;
        lsu_bus.araddr  = lsu_addr;
        lsu_bus.arvalid = lsu_req;
        exp_lsu  = model_pick_lsu(ifu_req, lsu_req);
        exp_addr = exp_lsu ? lsu_addr : ifu_addr;
        #1;
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_m_arvalid", 32'(mem_bus.arvalid), 32'(0));
        check("grant_ifu_arready", 32'(ifu_bus.arready), 32'(ifu_req && !exp_lsu));
        check("grant_lsu_arready", 32'(lsu_bus.arready), 32'(exp_lsu));
        @(posedge clk);
        model_update(ifu_req, exp_lsu);
        @(negedge clk);
        if (exp_lsu) lsu_bus.arvalid = 1'b0;
        else         ifu_bus.arvalid = 1'b0;

        for (int k = 0; k <= ar_wait; k++) begin
            mem_bus.arready = (k == ar_wait);
            #1;
            check("addr_m_arvalid", 32'(mem_bus.arvalid), 32'(1));
            check("addr_m_araddr", mem_bus.araddr, exp_addr);
            check("addr_owner", 32'(owner), 32'(exp_lsu));
            check("addr_ifu_arready", 32'(ifu_bus.arready), 32'(0));
            check("addr_lsu_arready", 32'(lsu_bus.arready), 32'(0));
            @(negedge clk);
        end
        mem_bus.arready = 1'b0;

        for (int k = 0; k <= r_wait + rr_wait; k++) begin
            rv  = (k >= r_wait);
            rel = (k == r_wait + rr_wait);
            mem_bus.rvalid = rv;
            mem_bus.rdata  = rv ? rdata : $urandom;
            mem_bus.rresp  = rresp;
            if (exp_lsu) begin
                lsu_bus.rready = rel;
                ifu_bus.rready = 1'($urandom_range(0, 1));
            end else begin
                ifu_bus.rready = rel;
                lsu_bus.rready = 1'($urandom_range(0, 1));
            end
            #1;
            check("data_m_arvalid", 32'(mem_bus.arvalid), 32'(0));
            check("data_busy", 32'(busy), 32'(1));
            check("data_owner_rvalid", 32'(exp_lsu ? lsu_bus.rvalid : ifu_bus.rvalid), 32'(rv));
            check("data_other_rvalid", 32'(exp_lsu ? ifu_bus.rvalid : lsu_bus.rvalid), 32'(0));
            check("data_m_rready", 32'(mem_bus.rready), 32'(rel));
            if (rv) begin
                check("data_ifu_rdata", ifu_bus.rdata, rdata);
                check("data_lsu_rdata", lsu_bus.rdata, rdata);
                check("data_rresp", 32'(exp_lsu ? lsu_bus.rresp : ifu_bus.rresp), 32'(rresp));
            end
            @(negedge clk);
        end
        mem_bus.rvalid = 1'b0;
        ifu_bus.rready = 1'b0;
        lsu_bus.rready = 1'b0;
        #1;
        check("done_busy", 32'(busy), 32'(0));
        check("done_owner_held", 32'(owner), 32'(exp_lsu));
        check("done_ifu_rvalid", 32'(ifu_bus.rvalid), 32'(0));
        check("done_lsu_rvalid", 32'(lsu_bus.rvalid), 32'(0));
    endtask

    initial begin
        bit          starve_seq [5];
        int          sel;
        logic [31:0] a0;
        logic [31:0] a1;

        starve_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        quiet_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_arvalid", 32'(mem_bus.arvalid), 32'(0));
        check("rst_m_araddr", mem_bus.araddr, 32'h0);
        check("rst_owner", 32'(owner), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        reset = 1'b1;

        // Single IFU read with a two-cycle slave data latency.
        do_txn(1'b1, 1'b0, 32'h3000_0000, 32'h0, 0, 2, 0, 32'h0000_0413, 2'b00);

        // Contention from streak 0: LSU first, then IFU once LSU drops.
        do_txn(1'b1, 1'b1, 32'h3000_0004, 32'h8000_0010, 0, 0, 0, 32'hCAFE_0001, 2'b00);
        check("contend_owner_lsu", 32'(owner), 32'(1));
        do_txn(1'b1, 1'b0, 32'h3000_0004, 32'h0, 0, 0, 0, 32'hCAFE_0002, 2'b00);
        check("contend_owner_ifu", 32'(owner), 32'(0));

        // Starvation bound: four LSU grants then IFU, then LSU again from streak 0.
        for (int i = 0; i < 5; i++) begin
            do_txn(1'b1, 1'b1, 32'h3000_0100, 32'h8000_0000 + 32'(i * 4), 0, 1, 0, 32'h1111_0000 + 32'(i), 2'b00);
            check("starve_owner", 32'(owner), 32'(starve_seq[i]));
        end
        do_txn(1'b1, 1'b1, 32'h3000_0104, 32'h8000_0040, 0, 0, 0, 32'h2222_0000, 2'b00);
        check("starve_reset_owner", 32'(owner), 32'(1));

        // R backpressure on IFU, AR stall on LSU, error response pass-through.
        do_txn(1'b1, 1'b0, 32'h3000_0200, 32'h0, 0, 0, 5, 32'hBEEF_0001, 2'b00);
        do_txn(1'b0, 1'b1, 32'h0, 32'h8000_0200, 3, 1, 0, 32'hBEEF_0002, 2'b10);
        do_txn(1'b1, 1'b0, 32'h3000_0300, 32'h0, 1, 0, 1, 32'hBEEF_0003, 2'b11);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(1, 3);
            a0  = $urandom;
            a1  = $urandom;
            do_txn(sel[0], sel[1], a0, a1, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)));
        end

        // Async reset while in S_DATA with IFU re-requesting.
        quiet_inputs();
        ifu_bus.araddr  = 32'h3000_0400;
        ifu_bus.arvalid = 1'b1;
        @(negedge clk);
        mem_bus.arready = 1'b1;
        @(negedge clk);
        mem_bus.arready = 1'b0;
        ifu_bus.rready  = 1'b1;
        #1;
        check("pre_rst_m_rready", 32'(mem_bus.rready), 32'(1));
        #1;
        reset = 1'b0;
        #1;
        check("async_m_arvalid", 32'(mem_bus.arvalid), 32'(0));
        check("async_m_rready", 32'(mem_bus.rready), 32'(0));
        check("async_ifu_arready", 32'(ifu_bus.arready), 32'(0));
        check("async_lsu_arready", 32'(lsu_bus.arready), 32'(0));
        check("async_ifu_rvalid", 32'(ifu_bus.rvalid), 32'(0));
        check("async_busy", 32'(busy), 32'(0));
        check("async_owner", 32'(owner), 32'(0));
        check("async_m_araddr", mem_bus.araddr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        ifu_bus.rready = 1'b0;
        streak_m = 0;
        do_txn(1'b1, 1'b0, 32'h3000_0500, 32'h0, 0, 1, 0, 32'h0000_0513, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
